// File: rtl/cfu_pkg.sv
// Constants shared by the SIMD int8 MAC CFU and its command-side initiator.
// The initiator's state encoding lives here so the CFU bench and RTL agree on it.
package cfu_pkg;

   localparam int unsigned CFU_FUNC_W = 10;

   localparam logic [CFU_FUNC_W-1:0] CFU_FN_MAC   = 10'd0;
   localparam logic [CFU_FUNC_W-1:0] CFU_FN_CLEAR = 10'd1;

   typedef enum logic [2:0] {
      StIdle,
      StClrCmd,
      StClrRsp,
      StFetch,
      StMacCmd,
      StMacRsp,
      StDone
   } init_state_e;

endpackage

// File: rtl/cfu_mac_initiator.sv
// Sequences a CFU dot product: one clear command, then N accumulate commands fed from an
// operand stream, returning the final accumulator. At most one command is in flight.
module cfu_mac_initiator
   import cfu_pkg::*;
#(
   parameter int unsigned              LEN_W         = 16,
   parameter logic [CFU_FUNC_W-1:0]    CLEAR_FUNC_ID = CFU_FN_CLEAR,
   parameter logic [CFU_FUNC_W-1:0]    MAC_FUNC_ID   = CFU_FN_MAC
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [LEN_W-1:0]      len,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           result,
   output logic                  err,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_data_0,
   input  logic [31:0]           in_data_1,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [CFU_FUNC_W-1:0] cmd_payload_function_id,
   output logic [31:0]           cmd_payload_inputs_0,
   output logic [31:0]           cmd_payload_inputs_1,
   input  logic                  rsp_valid,
   output logic                  rsp_ready,
   input  logic [31:0]           rsp_payload_outputs_0
);

   init_state_e      state_q, state_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic [31:0]      op0_q, op0_d;
   logic [31:0]      op1_q, op1_d;
   logic [31:0]      result_q, result_d;
   logic             err_q, err_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         op0_q       <= '0;
         op1_q       <= '0;
         result_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         op0_q       <= op0_d;
         op1_q       <= op1_d;
         result_q    <= result_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      op0_d       = op0_q;
      op1_d       = op1_q;
      result_d    = result_q;
      err_d       = err_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               remaining_d = len;
               err_d       = 1'b0;
               state_d     = StClrCmd;
            end
         end
         StClrCmd: begin
            if (cmd_ready) state_d = StClrRsp;
         end
         StClrRsp: begin
            if (rsp_valid) begin
               if (rsp_payload_outputs_0 != 32'd0) err_d = 1'b1;
               result_d = 32'd0;
               state_d  = (remaining_q != '0) ? StFetch : StDone;
            end
         end
         StFetch: begin
            if (in_valid) begin
               op0_d   = in_data_0;
               op1_d   = in_data_1;
               state_d = StMacCmd;
            end
         end
         StMacCmd: begin
            if (cmd_ready) begin
               remaining_d = remaining_q - LEN_W'(1);
               state_d     = StMacRsp;
            end
         end
         StMacRsp: begin
            if (rsp_valid) begin
               result_d = rsp_payload_outputs_0;
               state_d  = (remaining_q != '0) ? StFetch : StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Handshake outputs decode the state register only, so no input reaches an output.
   always_comb begin
      busy                    = 1'b1;
      done                    = 1'b0;
      in_ready                = 1'b0;
      cmd_valid               = 1'b0;
      rsp_ready               = 1'b0;
      cmd_payload_function_id = '0;
      cmd_payload_inputs_0    = 32'd0;
      cmd_payload_inputs_1    = 32'd0;

      case (state_q)
         StIdle:   busy = 1'b0;
         StClrCmd: begin
            cmd_valid               = 1'b1;
            cmd_payload_function_id = CLEAR_FUNC_ID;
         end
         StClrRsp: rsp_ready = 1'b1;
         StFetch:  in_ready  = 1'b1;
         StMacCmd: begin
            cmd_valid               = 1'b1;
            cmd_payload_function_id = MAC_FUNC_ID;
            cmd_payload_inputs_0    = op0_q;
            cmd_payload_inputs_1    = op1_q;
         end
         StMacRsp: rsp_ready = 1'b1;
         StDone:   done      = 1'b1;
         default:  busy      = 1'b0;
      endcase
   end

   assign result = result_q;
   assign err    = err_q;

endmodule

// File: tb/tb_cfu_mac_initiator.sv
// Directed bench for cfu_mac_initiator against a behavioural int8 MAC CFU with
// programmable cmd_ready / rsp_valid delays and a programmable clear response.
module tb_cfu_mac_initiator;
   import cfu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  reset;
   logic                  start;
   logic [15:0]           len;
   logic                  busy, done, err;
   logic [31:0]           result;
   logic                  in_valid, in_ready;
   logic [31:0]           in_data_0, in_data_1;
   logic                  cmd_valid, cmd_ready;
   logic [CFU_FUNC_W-1:0] cmd_payload_function_id;
   logic [31:0]           cmd_payload_inputs_0, cmd_payload_inputs_1;
   logic                  rsp_valid, rsp_ready;
   logic [31:0]           rsp_payload_outputs_0;

   cfu_mac_initiator dut (
      .clk                     (clk),
      .reset                   (reset),
      .start                   (start),
      .len                     (len),
      .busy                    (busy),
      .done                    (done),
      .result                  (result),
      .err                     (err),
      .in_valid                (in_valid),
      .in_ready                (in_ready),
      .in_data_0               (in_data_0),
      .in_data_1               (in_data_1),
      .cmd_valid               (cmd_valid),
      .cmd_ready               (cmd_ready),
      .cmd_payload_function_id (cmd_payload_function_id),
      .cmd_payload_inputs_0    (cmd_payload_inputs_0),
      .cmd_payload_inputs_1    (cmd_payload_inputs_1),
      .rsp_valid               (rsp_valid),
      .rsp_ready               (rsp_ready),
      .rsp_payload_outputs_0   (rsp_payload_outputs_0)
   );

   // ---------------- behavioural CFU (activation offset +128) ----------------
   int          cmd_delay = 0;
   int          rsp_delay = 1;
   logic [31:0] clear_rsp_val = 32'd0;

   logic        rsp_pending;
   int          rsp_cnt, cmd_wait;
   logic [31:0] acc, rsp_data;
   int          n_clear, n_mac, n_other, n_inrdy, stab_err;
   logic        hold;
   logic [73:0] held_payload;
   logic [73:0] payload;

   assign payload   = {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1};
   assign cmd_ready = cmd_valid && !rsp_pending && (cmd_wait >= cmd_delay);
   assign rsp_valid = rsp_pending && (rsp_cnt >= rsp_delay);
   assign rsp_payload_outputs_0 = rsp_valid ? rsp_data : 32'hDEAD_BEEF;

   function automatic logic [31:0] mac4(input logic [31:0] a, input logic [31:0] f);
      int s;
      s = 0;
      for (int i = 0; i < 4; i++)
         s += (int'($signed(a[8*i +: 8])) + 128) * int'($signed(f[8*i +: 8]));
      return 32'(s);
   endfunction

   always @(posedge clk) begin
      if (hold && (!cmd_valid || payload != held_payload)) stab_err <= stab_err + 1;
      if (in_ready) n_inrdy <= n_inrdy + 1;
      if (reset) begin
         rsp_pending <= 1'b0;
         rsp_cnt     <= 0;
         cmd_wait    <= 0;
         acc         <= 32'd0;
         hold        <= 1'b0;
      end else begin
         hold         <= cmd_valid && !cmd_ready;
         held_payload <= payload;
         if (cmd_valid && cmd_ready) begin
            rsp_pending <= 1'b1;
            rsp_cnt     <= 0;
            cmd_wait    <= 0;
            if (cmd_payload_function_id != 10'd0) begin
               acc      <= 32'd0;
               rsp_data <= clear_rsp_val;
               if (cmd_payload_function_id == 10'd1) n_clear <= n_clear + 1;
               else                                  n_other <= n_other + 1;
            end else begin
               acc      <= acc + mac4(cmd_payload_inputs_0, cmd_payload_inputs_1);
               rsp_data <= acc + mac4(cmd_payload_inputs_0, cmd_payload_inputs_1);
               n_mac    <= n_mac + 1;
            end
         end else if (cmd_valid) begin
            cmd_wait <= cmd_wait + 1;
         end
         if (rsp_pending) begin
            if (rsp_valid && rsp_ready) rsp_pending <= 1'b0;
            else                        rsp_cnt     <= rsp_cnt + 1;
         end
      end
   end

   initial begin
      n_clear = 0; n_mac = 0; n_other = 0; n_inrdy = 0; stab_err = 0;
      rsp_data = 32'd0; held_payload = '0;
   end

   // ---------------- checking helpers ----------------
   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Pulses start and waits (bounded) for done; cyc counts cycles from start to done.
   task automatic run(input logic [15:0] n, output int cyc, output bit busy_ok);
      busy_ok = 1'b1;
      @(negedge clk);
      len   = n;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (!done && cyc < 400) begin
         if (!busy) busy_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      if (!busy) busy_ok = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_hs"}, 32'({cmd_valid, rsp_ready, in_ready, busy, done, err}), 32'd0);
      check({tag, "_result"}, result, 32'd0);
      check({tag, "_fid"}, 32'(cmd_payload_function_id), 32'd0);
      check({tag, "_in0"}, cmd_payload_inputs_0, 32'd0);
      check({tag, "_in1"}, cmd_payload_inputs_1, 32'd0);
   endtask

   int cyc, c0, m0, o0, i0, s0, k;
   bit busy_ok;

   initial begin
      reset = 1'b1; start = 1'b0; len = 16'd0;
      in_valid = 1'b0; in_data_0 = 32'd0; in_data_1 = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      reset = 1'b0;

      // Single word: (-127+128)*2*4 = 8
      in_valid = 1'b1; in_data_0 = 32'h8181_8181; in_data_1 = 32'h0202_0202;
      c0 = n_clear; m0 = n_mac;
      run(16'd1, cyc, busy_ok);
      check("single_done", 32'(done), 32'd1);
      check("single_result", result, 32'd8);
      check("single_err", 32'(err), 32'd0);
      check("single_busy", 32'(busy_ok), 32'd1);
      check("single_cmds", 32'((n_clear - c0) * 16 + (n_mac - m0)), 32'h11);
      @(negedge clk);
      check("single_done_pulse", 32'({done, busy}), 32'd0);

      // Three words, same pair
      c0 = n_clear; m0 = n_mac; o0 = n_other;
      run(16'd3, cyc, busy_ok);
      check("three_done", 32'(done), 32'd1);
      check("three_result", result, 32'd24);
      check("three_clear_cmds", 32'(n_clear - c0), 32'd1);
      check("three_mac_cmds", 32'(n_mac - m0), 32'd3);
      check("three_other_cmds", 32'(n_other - o0), 32'd0);

      // Negative sum: 255 * -1 * 4 = -1020
      in_data_0 = 32'h7F7F_7F7F; in_data_1 = 32'hFFFF_FFFF;
      run(16'd1, cyc, busy_ok);
      check("neg_result", result, 32'hFFFF_FC04);

      // Zero length: clear only, done 4 cycles after start
      c0 = n_clear; m0 = n_mac; i0 = n_inrdy;
      run(16'd0, cyc, busy_ok);
      check("zero_done", 32'(done), 32'd1);
      check("zero_latency", 32'(cyc), 32'd4);
      check("zero_result", result, 32'd0);
      check("zero_cmds", 32'((n_clear - c0) * 16 + (n_mac - m0)), 32'h10);
      check("zero_in_ready", 32'(n_inrdy - i0), 32'd0);

      // Back-pressure: per word (132+131+130+129)*1 = 522, three words = 1566
      cmd_delay = 5; rsp_delay = 3;
      in_data_0 = 32'h0102_0304; in_data_1 = 32'h0101_0101;
      c0 = n_clear; m0 = n_mac; s0 = stab_err;
      run(16'd3, cyc, busy_ok);
      check("bp_done", 32'(done), 32'd1);
      check("bp_result", result, 32'h0000_061E);
      check("bp_cmds", 32'((n_clear - c0) * 16 + (n_mac - m0)), 32'h13);
      check("bp_stable", 32'(stab_err - s0), 32'd0);
      check("bp_busy", 32'(busy_ok), 32'd1);

      // Abort during the second MAC_RSP
      m0 = n_mac;
      @(negedge clk);
      len = 16'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!(rsp_ready && (n_mac - m0) == 2) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("abort_reached", 32'(rsp_ready), 32'd1);
      check("abort_pre_result", result, 32'd522);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("abort");
      @(negedge clk);
      reset = 1'b0;

      // Error on non-zero clear response, sticky until next start
      cmd_delay = 0; rsp_delay = 1; clear_rsp_val = 32'h5;
      in_data_0 = 32'h8181_8181; in_data_1 = 32'h0202_0202;
      run(16'd1, cyc, busy_ok);
      check("err_set", 32'(err), 32'd1);
      check("err_result", result, 32'd8);
      repeat (5) @(negedge clk);
      check("err_sticky", 32'(err), 32'd1);
      clear_rsp_val = 32'd0;
      @(negedge clk);
      len = 16'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("err_cleared", 32'(err), 32'd0);
      k = 0;
      while (!done && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("err_final_done", 32'(done), 32'd1);
      check("err_final", 32'(err), 32'd0);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
